// File: rtl/branch_sched_if.sv
// Dispatch, result-bus and commit handshake signals for the branch resolve controller.
// The master side is the surrounding pipeline; the slave side is branch_sched.
interface branch_sched_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    // Dispatch side
    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_pc;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_imm;
    logic             req_pred_taken;
    logic [TAG_W-1:0] req_tagx;
    logic [TAG_W-1:0] req_tagy;
    logic [XLEN-1:0]  req_datax;
    logic [XLEN-1:0]  req_datay;

    // Result buses
    logic             cdb_alu0_valid;
    logic [TAG_W-1:0] cdb_alu0_tag;
    logic [XLEN-1:0]  cdb_alu0_data;
    logic             cdb_alu1_valid;
    logic [TAG_W-1:0] cdb_alu1_tag;
    logic [XLEN-1:0]  cdb_alu1_data;
    logic             cdb_ls_valid;
    logic [TAG_W-1:0] cdb_ls_tag;
    logic [XLEN-1:0]  cdb_ls_data;

    // Commit side
    logic             resolve_valid;
    logic             resolve_ready;
    logic             resolve_taken;
    logic             resolve_mispredict;
    logic [XLEN-1:0]  resolve_target;

    modport master (
        output req_valid, req_pc, req_op, req_imm, req_pred_taken,
               req_tagx, req_tagy, req_datax, req_datay,
               cdb_alu0_valid, cdb_alu0_tag, cdb_alu0_data,
               cdb_alu1_valid, cdb_alu1_tag, cdb_alu1_data,
               cdb_ls_valid, cdb_ls_tag, cdb_ls_data,
               resolve_ready,
        input  req_ready, resolve_valid, resolve_taken,
               resolve_mispredict, resolve_target
    );

    modport slave (
        input  req_valid, req_pc, req_op, req_imm, req_pred_taken,
               req_tagx, req_tagy, req_datax, req_datay,
               cdb_alu0_valid, cdb_alu0_tag, cdb_alu0_data,
               cdb_alu1_valid, cdb_alu1_tag, cdb_alu1_data,
               cdb_ls_valid, cdb_ls_tag, cdb_ls_data,
               resolve_ready,
        output req_ready, resolve_valid, resolve_taken,
               resolve_mispredict, resolve_target
    );
endinterface

// File: rtl/branch_sched.sv
// Single-entry conditional branch controller: waits for both operands on the result
// buses, evaluates the condition and holds the redirect result until commit takes it.
module branch_sched #(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 4,
    parameter int UNLOCKED_TAG = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    branch_sched_if.slave    bif,
    output logic             busy,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam logic [TAG_W-1:0] UNLOCK = TAG_W'(UNLOCKED_TAG);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        EVAL     = 2'd2,
        RESOLVE  = 2'd3
    } state_t;

    state_t state, state_d;

    logic [XLEN-1:0]  pc_q, imm_q, datax_q, datay_q;
    logic [2:0]       op_q;
    logic             pred_q;
    logic [TAG_W-1:0] tagx_q, tagy_q;

    logic             res_taken_q, res_mis_q;
    logic [XLEN-1:0]  res_target_q;
    logic [CNT_W-1:0] cnt_q;

    logic [TAG_W-1:0] src_tagx, src_tagy, eff_tagx, eff_tagy;
    logic [XLEN-1:0]  src_datax, src_datay, eff_datax, eff_datay;
    logic             ops_ready, req_ready_c, accept, capture, cnt_inc;
    logic             taken_c, mis_c;
    logic [XLEN-1:0]  target_c;

    // A locked operand takes the first matching bus in alu0 > alu1 > ls order.
    // Unlocked operands are never touched, so a bus carrying UNLOCK cannot match.
    function automatic logic [TAG_W+XLEN-1:0] snoop(
        input logic [TAG_W-1:0] tag,
        input logic [XLEN-1:0]  data,
        input logic             v0,
        input logic [TAG_W-1:0] t0,
        input logic [XLEN-1:0]  d0,
        input logic             v1,
        input logic [TAG_W-1:0] t1,
        input logic [XLEN-1:0]  d1,
        input logic             v2,
        input logic [TAG_W-1:0] t2,
        input logic [XLEN-1:0]  d2
    );
        logic [TAG_W+XLEN-1:0] r;
        r = {tag, data};
        if (tag != UNLOCK) begin
            if (v0 && (t0 == tag))      r = {UNLOCK, d0};
            else if (v1 && (t1 == tag)) r = {UNLOCK, d1};
            else if (v2 && (t2 == tag)) r = {UNLOCK, d2};
        end
        return r;
    endfunction

    function automatic logic cond_taken(
        input logic [2:0]      op,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y
    );
        logic signed [XLEN-1:0] sx, sy;
        logic                   t;
        sx = x;
        sy = y;
        case (op)
            3'b000:  t = (x == y);
            3'b001:  t = (x != y);
            3'b100:  t = (sx < sy);
            3'b101:  t = (sx >= sy);
            3'b110:  t = (x < y);
            3'b111:  t = (x >= y);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Operand sources: the dispatch bus while idle (accept-cycle bypass), else the entry.
    always_comb begin
        src_tagx  = (state == IDLE) ? bif.req_tagx  : tagx_q;
        src_tagy  = (state == IDLE) ? bif.req_tagy  : tagy_q;
        src_datax = (state == IDLE) ? bif.req_datax : datax_q;
        src_datay = (state == IDLE) ? bif.req_datay : datay_q;
        {eff_tagx, eff_datax} = snoop(src_tagx, src_datax,
            bif.cdb_alu0_valid, bif.cdb_alu0_tag, bif.cdb_alu0_data,
            bif.cdb_alu1_valid, bif.cdb_alu1_tag, bif.cdb_alu1_data,
            bif.cdb_ls_valid,   bif.cdb_ls_tag,   bif.cdb_ls_data);
        {eff_tagy, eff_datay} = snoop(src_tagy, src_datay,
            bif.cdb_alu0_valid, bif.cdb_alu0_tag, bif.cdb_alu0_data,
            bif.cdb_alu1_valid, bif.cdb_alu1_tag, bif.cdb_alu1_data,
            bif.cdb_ls_valid,   bif.cdb_ls_tag,   bif.cdb_ls_data);
        ops_ready = (eff_tagx == UNLOCK) && (eff_tagy == UNLOCK);
    end

    always_comb begin
        taken_c  = cond_taken(op_q, datax_q, datay_q);
        target_c = taken_c ? (pc_q + imm_q) : (pc_q + XLEN'(4));
        mis_c    = (taken_c != pred_q);
    end

    always_comb begin
        state_d     = state;
        req_ready_c = (state == IDLE) && !flush;
        accept      = bif.req_valid && req_ready_c;
        capture     = accept || ((state == WAIT_OPS) && !flush);
        cnt_inc     = (state == RESOLVE) && bif.resolve_ready && res_mis_q && !flush;
        case (state)
            IDLE:     if (accept) state_d = ops_ready ? EVAL : WAIT_OPS;
            WAIT_OPS: if (ops_ready) state_d = EVAL;
            EVAL:     state_d = RESOLVE;
            RESOLVE:  if (bif.resolve_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Entry capture: dispatch fields on accept, bus snoop results while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            imm_q   <= '0;
            op_q    <= '0;
            pred_q  <= 1'b0;
            tagx_q  <= UNLOCK;
            tagy_q  <= UNLOCK;
            datax_q <= '0;
            datay_q <= '0;
        end else if (flush) begin
            tagx_q <= UNLOCK;
            tagy_q <= UNLOCK;
        end else begin
            if (accept) begin
                pc_q   <= bif.req_pc;
                imm_q  <= bif.req_imm;
                op_q   <= bif.req_op;
                pred_q <= bif.req_pred_taken;
            end
            if (capture) begin
                tagx_q  <= eff_tagx;
                tagy_q  <= eff_tagy;
                datax_q <= eff_datax;
                datay_q <= eff_datay;
            end
        end
    end

    // Resolve result registers and the mispredict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_taken_q  <= 1'b0;
            res_mis_q    <= 1'b0;
            res_target_q <= '0;
            cnt_q        <= '0;
        end else begin
            if ((state == EVAL) && !flush) begin
                res_taken_q  <= taken_c;
                res_mis_q    <= mis_c;
                res_target_q <= target_c;
            end
            if (cnt_inc) cnt_q <= sat_inc(cnt_q);
        end
    end

    assign bif.req_ready          = req_ready_c;
    assign bif.resolve_valid      = (state == RESOLVE);
    assign bif.resolve_taken      = res_taken_q;
    assign bif.resolve_mispredict = res_mis_q;
    assign bif.resolve_target     = res_target_q;
    assign busy                   = (state != IDLE);
    assign mispredict_cnt         = cnt_q;
endmodule

// File: tb/tb_branch_sched.sv
// Directed bench for branch_sched: hand-computed branch outcomes, snoop priority,
// bypass, flush, counter saturation (CNT_W=2) and asynchronous reset.
module tb_branch_sched;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int CNT_W = 2;
    localparam logic [TAG_W-1:0] UNL = 4'd15;
    localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100,
                           BGE = 3'b101, BLTU = 3'b110;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] mispredict_cnt;
    int               n_tests = 0;
    int               n_fail  = 0;

    branch_sched_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bif ();

    branch_sched #(
        .XLEN(XLEN), .TAG_W(TAG_W), .UNLOCKED_TAG(15), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bif(bif),
        .busy(busy),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_bus();
        bif.cdb_alu0_valid = 1'b0; bif.cdb_alu0_tag = '0; bif.cdb_alu0_data = '0;
        bif.cdb_alu1_valid = 1'b0; bif.cdb_alu1_tag = '0; bif.cdb_alu1_data = '0;
        bif.cdb_ls_valid   = 1'b0; bif.cdb_ls_tag   = '0; bif.cdb_ls_data   = '0;
    endtask

    task automatic drive_req(input logic [31:0] pc, input logic [2:0] op, input logic [31:0] imm,
                             input logic pred, input logic [3:0] tx, input logic [3:0] ty,
                             input logic [31:0] dx, input logic [31:0] dy);
        bif.req_pc = pc; bif.req_op = op; bif.req_imm = imm; bif.req_pred_taken = pred;
        bif.req_tagx = tx; bif.req_tagy = ty; bif.req_datax = dx; bif.req_datay = dy;
    endtask

    // One accept edge; returns 1 ns after it with req_valid dropped.
    task automatic send(input logic [31:0] pc, input logic [2:0] op, input logic [31:0] imm,
                        input logic pred, input logic [3:0] tx, input logic [3:0] ty,
                        input logic [31:0] dx, input logic [31:0] dy);
        drive_req(pc, op, imm, pred, tx, ty, dx, dy);
        bif.req_valid = 1'b1;
        step();
        bif.req_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic taken, input logic [31:0] target,
                             input logic mis);
        check({tag, ".valid"},  bif.resolve_valid, 1'b1);
        check({tag, ".taken"},  bif.resolve_taken, taken);
        check({tag, ".target"}, bif.resolve_target, target);
        check({tag, ".mis"},    bif.resolve_mispredict, mis);
    endtask

    task automatic handshake();
        bif.resolve_ready = 1'b1;
        step();
        bif.resolve_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bif.req_valid = 1'b0; bif.resolve_ready = 1'b0;
        drive_req(0, 0, 0, 0, UNL, UNL, 0, 0);
        clear_bus();
        step(2);
        check("rst.busy", busy, 1'b0);
        check("rst.valid", bif.resolve_valid, 1'b0);
        check("rst.target", bif.resolve_target, 32'h0);
        check("rst.cnt", mispredict_cnt, 2'd0);
        rst = 1'b0;
        step();
        check("rst.req_ready", bif.req_ready, 1'b1);

        // BEQ 5==5, predicted not taken: mispredict, then held stable.
        send(32'h100, BEQ, 32'h20, 1'b0, UNL, UNL, 32'd5, 32'd5);
        check("beq.eval_valid", bif.resolve_valid, 1'b0);
        check("beq.busy", busy, 1'b1);
        check("beq.req_ready", bif.req_ready, 1'b0);
        step();
        check_res("beq", 1'b1, 32'h120, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_res("beq.hold", 1'b1, 32'h120, 1'b1);
        end
        handshake();
        check("beq.cnt", mispredict_cnt, 2'd1);
        check("beq.idle_ready", bif.req_ready, 1'b1);
        check("beq.idle_valid", bif.resolve_valid, 1'b0);

        // BLTU 0xFFFFFFFF < 1 is false; x arrives on ls.
        send(32'h200, BLTU, 32'h40, 1'b0, 4'd3, UNL, 32'h0, 32'd1);
        step(3);
        check("bltu.wait_valid", bif.resolve_valid, 1'b0);
        check("bltu.wait_busy", busy, 1'b1);
        bif.cdb_ls_valid = 1'b1; bif.cdb_ls_tag = 4'd3; bif.cdb_ls_data = 32'hFFFF_FFFF;
        step();
        clear_bus();
        check("bltu.eval_valid", bif.resolve_valid, 1'b0);
        step();
        check_res("bltu", 1'b0, 32'h204, 1'b0);
        handshake();
        check("bltu.cnt", mispredict_cnt, 2'd1);

        // BLT -1 < 1 is true.
        send(32'h200, BLT, 32'h40, 1'b0, 4'd3, UNL, 32'h0, 32'd1);
        step(3);
        bif.cdb_ls_valid = 1'b1; bif.cdb_ls_tag = 4'd3; bif.cdb_ls_data = 32'hFFFF_FFFF;
        step();
        clear_bus();
        step();
        check_res("blt", 1'b1, 32'h240, 1'b1);
        handshake();
        check("blt.cnt", mispredict_cnt, 2'd2);

        // Flush while waiting; a request offered during flush is refused.
        send(32'h500, BEQ, 32'h0, 1'b0, 4'd4, UNL, 32'h0, 32'h0);
        step();
        check("flw.busy", busy, 1'b1);
        flush = 1'b1;
        drive_req(32'h510, BEQ, 32'h0, 1'b0, UNL, UNL, 32'h0, 32'h0);
        bif.req_valid = 1'b1;
        #1;
        check("flw.req_ready", bif.req_ready, 1'b0);
        step();
        flush = 1'b0; bif.req_valid = 1'b0;
        check("flw.busy_after", busy, 1'b0);
        check("flw.valid_after", bif.resolve_valid, 1'b0);
        step();
        check("flw.no_accept", busy, 1'b0);

        // Flush in RESOLVE coinciding with resolve_ready: counter must not move.
        send(32'h600, BEQ, 32'h10, 1'b0, UNL, UNL, 32'd3, 32'd3);
        step();
        check("flr.valid", bif.resolve_valid, 1'b1);
        flush = 1'b1; bif.resolve_ready = 1'b1;
        step();
        flush = 1'b0; bif.resolve_ready = 1'b0;
        check("flr.valid_after", bif.resolve_valid, 1'b0);
        check("flr.busy_after", busy, 1'b0);
        check("flr.cnt", mispredict_cnt, 2'd2);

        // Accept-cycle bypass from alu1: BNE 7 != 7 is false, predicted taken.
        bif.cdb_alu1_valid = 1'b1; bif.cdb_alu1_tag = 4'd2; bif.cdb_alu1_data = 32'd7;
        send(32'h300, BNE, 32'h10, 1'b1, 4'd2, UNL, 32'h0, 32'd7);
        clear_bus();
        check("byp.eval_valid", bif.resolve_valid, 1'b0);
        step();
        check_res("byp", 1'b0, 32'h304, 1'b1);
        handshake();
        check("byp.cnt", mispredict_cnt, 2'd3);

        // UNLOCK-tagged buses are ignored; alu0 beats ls on a shared tag.
        send(32'h400, BEQ, 32'h8, 1'b1, 4'd5, UNL, 32'h0, 32'd1);
        bif.cdb_alu0_valid = 1'b1; bif.cdb_alu0_tag = UNL; bif.cdb_alu0_data = 32'd9;
        bif.cdb_alu1_valid = 1'b1; bif.cdb_alu1_tag = UNL; bif.cdb_alu1_data = 32'd9;
        bif.cdb_ls_valid   = 1'b1; bif.cdb_ls_tag   = UNL; bif.cdb_ls_data   = 32'd9;
        step(2);
        check("unl.valid", bif.resolve_valid, 1'b0);
        check("unl.busy", busy, 1'b1);
        clear_bus();
        bif.cdb_alu0_valid = 1'b1; bif.cdb_alu0_tag = 4'd5; bif.cdb_alu0_data = 32'd1;
        bif.cdb_ls_valid   = 1'b1; bif.cdb_ls_tag   = 4'd5; bif.cdb_ls_data   = 32'd9;
        step();
        clear_bus();
        step();
        check_res("prio", 1'b1, 32'h408, 1'b0);
        handshake();

        // Undefined op, pc+4 wrap; one more mispredict at a saturated counter.
        send(32'hFFFF_FFFC, 3'b010, 32'h100, 1'b1, UNL, UNL, 32'd0, 32'd0);
        step();
        check_res("undef", 1'b0, 32'h0, 1'b1);
        handshake();
        check("sat.cnt", mispredict_cnt, 2'd3);

        // BGE -5 >= -5 with wrapping pc+imm.
        send(32'hFFFF_FFF0, BGE, 32'h20, 1'b1, UNL, UNL, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
        step();
        check_res("bge", 1'b1, 32'h10, 1'b0);
        handshake();

        // Asynchronous reset in WAIT_OPS, observed before the next clock edge.
        send(32'h700, BEQ, 32'h0, 1'b0, 4'd6, UNL, 32'h0, 32'h0);
        check("arst.pre_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst.busy", busy, 1'b0);
        check("arst.valid", bif.resolve_valid, 1'b0);
        check("arst.taken", bif.resolve_taken, 1'b0);
        check("arst.target", bif.resolve_target, 32'h0);
        check("arst.cnt", mispredict_cnt, 2'd0);
        step();
        rst = 1'b0;
        step();
        check("arst.req_ready", bif.req_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
